// File: rtl/pkt_commit_fifo.sv
// pkt_commit_fifo: synchronous FIFO with packet-level commit/abort.
// Data written after the last commit is invisible to the reader until it is
// published by w_commit, or it is thrown away by w_abort. The three pointers
// carry an extra wrap bit, so all DEPTH entries are usable.
module pkt_commit_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              w_enable,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_commit,
  input  logic              w_abort,
  input  logic              r_enable,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_L    = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] ZERO_L  = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};

  // Storage, deliberately without reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Pointer and sticky-flag state.
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] commit_ptr_q, commit_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  // Derived status.
  logic [ADDR_W:0] used_s;
  logic [ADDR_W:0] count_s;
  logic            empty_s;
  logic            full_s;
  logic            wr_acc_s;
  logic            rd_acc_s;
  logic            mem_we_s;
  logic [ADDR_W:0] wr_inc_s;

  assign used_s   = wr_ptr_q - rd_ptr_q;
  assign count_s  = commit_ptr_q - rd_ptr_q;
  assign empty_s  = (count_s == ZERO_L);
  assign full_s   = (used_s == DEPTH_L);
  assign wr_acc_s = w_enable & ~full_s;
  assign rd_acc_s = r_enable & ~empty_s;
  assign wr_inc_s = wr_acc_s ? (wr_ptr_q + ONE_L) : wr_ptr_q;
  // An aborted or flushed write never needs to reach memory.
  assign mem_we_s = wr_acc_s & ~w_abort & ~clear;

  // Next-state for pointers and sticky error flags; clear overrides all.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    if (clear) begin
      wr_ptr_d     = ZERO_L;
      commit_ptr_d = ZERO_L;
      rd_ptr_d     = ZERO_L;
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
    end else begin
      // Abort wins over commit and drops any same-cycle write.
      if (w_abort) begin
        wr_ptr_d     = commit_ptr_q;
        commit_ptr_d = commit_ptr_q;
      end else if (w_commit) begin
        wr_ptr_d     = wr_inc_s;
        commit_ptr_d = wr_inc_s;
      end else begin
        wr_ptr_d     = wr_inc_s;
        commit_ptr_d = commit_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + ONE_L;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      overflow_d  = overflow_q | (w_enable & full_s);
      underflow_d = underflow_q | (r_enable & empty_s);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= ZERO_L;
      commit_ptr_q <= ZERO_L;
      rd_ptr_q     <= ZERO_L;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= w_data;
    end
  end

  // Outputs: first-word-fall-through head, zero when nothing is committed.
  assign r_data      = empty_s ? {DATA_W{1'b0}} : mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign empty       = empty_s;
  assign full        = full_s;
  assign almost_full = (used_s >= AF_L);
  assign count       = count_s;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_pkt_commit_fifo.sv
// Directed self-checking bench for pkt_commit_fifo (DATA_W=8, DEPTH=16, AF_THRESH=12).
module tb_pkt_commit_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       w_enable;
  logic [7:0] w_data;
  logic       w_commit;
  logic       w_abort;
  logic       r_enable;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_errors = 0;

  pkt_commit_fifo #(
    .DATA_W(8),
    .DEPTH(16),
    .AF_THRESH(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .w_enable(w_enable),
    .w_data(w_data),
    .w_commit(w_commit),
    .w_abort(w_abort),
    .r_enable(r_enable),
    .r_data(r_data),
    .empty(empty),
    .full(full),
    .almost_full(almost_full),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one clock edge, then return to idle 1ns after the edge.
  task automatic step(input logic we, input logic [7:0] wd, input logic wc,
                      input logic wa, input logic re, input logic cl);
    w_enable = we;
    w_data   = wd;
    w_commit = wc;
    w_abort  = wa;
    r_enable = re;
    clear    = cl;
    @(posedge clk);
    #1;
    w_enable = 1'b0;
    w_data   = 8'h00;
    w_commit = 1'b0;
    w_abort  = 1'b0;
    r_enable = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, {31'd0, empty}, 32'd1);
    check({tag, "_full"}, {31'd0, full}, 32'd0);
    check({tag, "_af"}, {31'd0, almost_full}, 32'd0);
    check({tag, "_count"}, {27'd0, count}, 32'd0);
    check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    check({tag, "_unf"}, {31'd0, underflow}, 32'd0);
    check({tag, "_rdata"}, {24'd0, r_data}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0; w_enable = 1'b0; w_data = 8'h00;
    w_commit = 1'b0; w_abort = 1'b0; r_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // Full packet of 16, committed on the last beat, then drained in order.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), (i == 15), 1'b0, 1'b0, 1'b0);
      if (i < 15) begin
        check("fill_count_hidden", {27'd0, count}, 32'd0);
        check("fill_empty_hidden", {31'd0, empty}, 32'd1);
      end
    end
    check("commit_count", {27'd0, count}, 32'd16);
    check("commit_full", {31'd0, full}, 32'd1);
    check("commit_empty", {31'd0, empty}, 32'd0);
    check("commit_af", {31'd0, almost_full}, 32'd1);
    check("commit_head", {24'd0, r_data}, 32'h00);
    for (int i = 0; i < 16; i++) begin
      check("drain_data", {24'd0, r_data}, 32'(i));
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("drain_count", {27'd0, count}, 32'd0);
    check("drain_full", {31'd0, full}, 32'd0);

    // Abort of an uncommitted packet, then a committed single word.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("abort_count", {27'd0, count}, 32'd0);
    check("abort_empty", {31'd0, empty}, 32'd1);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_abort_count", {27'd0, count}, 32'd1);
    check("post_abort_data", {24'd0, r_data}, 32'h55);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("post_abort_empty", {31'd0, empty}, 32'd1);

    // Overflow when full, underflow when empty, both sticky until clear.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'h30 + 8'(i), (i == 15), 1'b0, 1'b0, 1'b0);
    end
    check("ovf_pre_full", {31'd0, full}, 32'd1);
    check("ovf_pre_flag", {31'd0, overflow}, 32'd0);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_count", {27'd0, count}, 32'd16);
    check("ovf_head", {24'd0, r_data}, 32'h30);
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain_data", {24'd0, r_data}, 32'h30 + 32'(i));
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("ovf_drained_empty", {31'd0, empty}, 32'd1);
    check("unf_pre_flag", {31'd0, underflow}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("unf_flag", {31'd0, underflow}, 32'd1);
    check("unf_rdata", {24'd0, r_data}, 32'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("unf_sticky", {31'd0, underflow}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check_reset_state("clear_flags");

    // Almost-full threshold at 12 used entries.
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 8'(i), (i == 10), 1'b0, 1'b0, 1'b0);
    end
    check("af_11", {31'd0, almost_full}, 32'd0);
    check("af_11_count", {27'd0, count}, 32'd11);
    step(1'b1, 8'h0B, 1'b1, 1'b0, 1'b0, 1'b0);
    check("af_12", {31'd0, almost_full}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("af_11_after_read", {31'd0, almost_full}, 32'd0);
    check("af_read_count", {27'd0, count}, 32'd11);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Three rounds of 10 across the pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        step(1'b1, 8'(r * 10 + i), (i == 9), 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
        check("wrap_count", {27'd0, count}, 32'(10 - i));
        check("wrap_data", {24'd0, r_data}, 32'(r * 10 + i));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      check("wrap_empty", {31'd0, empty}, 32'd1);
    end

    // Concurrent read + write + commit at count 8.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'hC0 + 8'(i), (i == 7), 1'b0, 1'b0, 1'b0);
    end
    check("rwc_pre_count", {27'd0, count}, 32'd8);
    check("rwc_pre_head", {24'd0, r_data}, 32'hC0);
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0);
    check("rwc_count", {27'd0, count}, 32'd8);
    check("rwc_head", {24'd0, r_data}, 32'hC1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-packet with 7 committed and 2 pending.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 8'h60 + 8'(i), (i == 6), 1'b0, 1'b0, 1'b0);
    end
    check("arst_pre_count", {27'd0, count}, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("arst_after_count", {27'd0, count}, 32'd0);

    // clear beats a same-cycle write + commit.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h11 + 8'(i), (i == 2), 1'b0, 1'b0, 1'b0);
    end
    check("clr_pre_count", {27'd0, count}, 32'd3);
    step(1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1);
    check("clr_count", {27'd0, count}, 32'd0);
    check("clr_empty", {31'd0, empty}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("clr_idle_count", {27'd0, count}, 32'd0);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    check("clr_then_data", {24'd0, r_data}, 32'h77);
    check("clr_then_count", {27'd0, count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pkt_commit_fifo.md
Name: pkt_commit_fifo

Overview:
- Parametrised successor to the fixed 8-bit x16 encrypted-data FIFO.
- Buffers bytes/words between the AES encryption core and the USB transmit path.
- Adds packet-level write commit/abort: the reader sees only committed data, so a partially encrypted block can be dropped.
- Also provides an occupancy count, a programmable almost-full flag, a synchronous flush and sticky overflow/underflow error flags.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 16, number of entries; power of two, >= 4
ADDR_W, $clog2(DEPTH), pointer index width (derived, not overridden)
AF_THRESH, DEPTH-4, almost_full asserts when used entries >= AF_THRESH; range 1..DEPTH

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
clear  in  1  synchronous flush, one-cycle pulse
w_enable  in  1  write request
w_data  in  DATA_W  write data
w_commit  in  1  publish all pending writes, including a same-cycle accepted write
w_abort  in  1  discard all uncommitted writes, including a same-cycle write
r_enable  in  1  pop head entry
r_data  out  DATA_W  head entry, first-word-fall-through
empty  out  1  no committed entries
full  out  1  used entries == DEPTH
almost_full  out  1  used entries >= AF_THRESH
count  out  ADDR_W+1  committed entries available to the reader
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, commit_ptr, rd_ptr = 0.
  - empty=1, full=0, almost_full=0, count=0, overflow=0, underflow=0, r_data=0.
  - Memory is not reset.
- Pointers are ADDR_W+1 bits wide; the MSB is the wrap bit.
  - used = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
  - count = commit_ptr - rd_ptr.
- empty = (count==0). full = (used==DEPTH). almost_full = (used>=AF_THRESH). All are combinational from registered pointers, so they update one cycle after the causing edge.
- Write:
  - Accepted iff w_enable=1 and full=0 (current-cycle state). Memory[wr_ptr] <= w_data, wr_ptr++.
  - w_enable=1 with full=1 has no pointer or memory change and sets overflow.
  - A same-cycle read does not free space for a write when full.
- Commit: w_commit=1 sets commit_ptr <= next wr_ptr, i.e. it includes a write accepted in the same cycle.
- Abort:
  - w_abort=1 sets wr_ptr <= commit_ptr; any same-cycle write is discarded (no memory update needed).
  - w_abort has priority over w_commit when both are asserted.
  - An aborted write while full still sets overflow.
- Read:
  - r_data = memory[rd_ptr] when empty=0, else 0 (combinational mux).
  - r_enable=1 with empty=0 gives rd_ptr++; the next head appears the following cycle.
  - r_enable=1 with empty=1 has no change and sets underflow.
  - Reads never pass commit_ptr, so uncommitted data is never visible.
- Simultaneous events:
  - A read plus a write in the same cycle, each individually legal, both take effect.
  - Read+write+commit in one cycle: count changes by (+1 newly committed) -1 +(pending before commit).
- Wrap-around: pointers wrap naturally. full vs empty is distinguished by the MSB, with no lost entry: all DEPTH entries are usable.
- clear:
  - Takes priority over every other input in that cycle.
  - All pointers to 0, overflow/underflow to 0; outputs as after reset from the next cycle.
- rst mid-packet drops all data, committed and uncommitted, immediately.
- overflow/underflow stay set until rst or clear.

Test Plan:
- DATA_W=8, DEPTH=16, AF_THRESH=12. Write 0x00..0x0F with w_commit on the last beat -> empty=1 and count=0 through beat 15. Cycle after the commit: count=16, full=1, empty=0, r_data=0x00. Then 16 reads return 0x00..0x0F in order, and empty=1 after the last.
- Write 5 words (0xA0..0xA4) without commit, then w_abort -> count stays 0 and empty=1. The next committed write of 0x55 reads back as 0x55 (not 0xA0).
- Fill to 16 used, then w_enable with 0xEE -> overflow=1, wr_ptr unchanged, data unchanged. Read on empty after draining -> underflow=1. Both flags held until clear, then both 0.
- Almost-full: writes 11 -> almost_full=0; write 12 -> almost_full=1 the next cycle; one read -> almost_full=0 the next cycle.
- Wrap: 3 rounds of write 10 / commit / read 10 with an incrementing pattern -> data integrity across the pointer wrap and count correct each cycle. Concurrent read+write+commit at count=8 -> count=8 next cycle (one in, one out).
- Assert rst asynchronously mid-packet, between clock edges, with count=7 -> all outputs reach reset values before the next edge. clear with w_enable and w_commit high -> the write is dropped and count=0.
